// File: rtl/pulse_train_rx_pkg.sv
// Shared state encoding and width-window derivation for the pulse-train receiver.
package pulse_train_rx_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HIGH = 2'd1;
   localparam logic [1:0] LOW  = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   function automatic int calc_min(input int half_period, input int tolerance);
      return half_period - tolerance;
   endfunction

   function automatic int calc_max(input int half_period, input int tolerance);
      return half_period + tolerance;
   endfunction

   // One clock beyond the longest legal low half-period marks the end of a burst.
   function automatic int calc_gap(input int half_period, input int tolerance);
      return half_period + tolerance + 1;
   endfunction

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pulse_train_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on rst_n.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pulse_train_rx.sv
// Pulse-train receiver: checks high/low widths of each pulse, strobes valid or err per burst.
// Define PULSE_TRAIN_RX_STATS_EN to add saturating ok_count / err_count outputs.
//
// state | meaning
// IDLE  | waiting for the first rise of a burst
// HIGH  | timing a high half-period
// LOW   | timing a low half-period, or the closing idle gap after the last pulse
// ERR   | malformed burst seen; waiting for GAP consecutive low cycles
module pulse_train_rx
   import pulse_train_rx_pkg::*;
#(
   parameter int CLKS_PER_HALF_PERIOD = 2,
   parameter int PULSES               = 3,
   parameter int TOLERANCE            = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in,
   output logic        valid,
   output logic        err,
   output logic        busy
`ifdef PULSE_TRAIN_RX_STATS_EN
   ,
   output logic [15:0] ok_count,
   output logic [15:0] err_count
`endif
);

   localparam int MIN_W  = calc_min(CLKS_PER_HALF_PERIOD, TOLERANCE);
   localparam int MAX_W  = calc_max(CLKS_PER_HALF_PERIOD, TOLERANCE);
   localparam int GAP_W  = calc_gap(CLKS_PER_HALF_PERIOD, TOLERANCE);
   localparam int WCNT_W = cnt_width(GAP_W);
   localparam int PCNT_W = cnt_width(PULSES);

   localparam logic [WCNT_W-1:0] MIN_C     = WCNT_W'(MIN_W);
   localparam logic [WCNT_W-1:0] GAP_C     = WCNT_W'(GAP_W);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = 1;
   localparam logic [WCNT_W:0]   MAX_X     = (WCNT_W + 1)'(MAX_W);
   localparam logic [WCNT_W:0]   GAP_X     = (WCNT_W + 1)'(GAP_W);
   localparam logic [WCNT_W:0]   WCNT_ONEX = 1;
   localparam logic [PCNT_W-1:0] PULSES_C  = PCNT_W'(PULSES);
   localparam logic [PCNT_W-1:0] PCNT_ONE  = 1;

   if (TOLERANCE < 0 || TOLERANCE >= CLKS_PER_HALF_PERIOD || PULSES < 1) begin : g_param_check
      $error("pulse_train_rx: requires 0 <= TOLERANCE < CLKS_PER_HALF_PERIOD and PULSES >= 1");
   end

   logic              in_sync;
   logic              in_d;
   logic              rise;
   logic              fall;
   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [WCNT_W-1:0] wcnt_nxt;
   logic [WCNT_W-1:0] wcnt_sat;
   logic [WCNT_W:0]   wcnt_inc;
   logic [PCNT_W-1:0] pcnt;
   logic [PCNT_W-1:0] pcnt_nxt;
   logic              valid_nxt;
   logic              err_nxt;
   logic              too_long;
   logic              last_pulse;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in),
      .q     (in_sync)
   );

   assign rise = in_sync & ~in_d;
   assign fall = ~in_sync & in_d;

   // wcnt lags the true level age by one, so wcnt_inc is the width including this cycle.
   assign wcnt_inc   = {1'b0, wcnt} + WCNT_ONEX;
   assign wcnt_sat   = (wcnt == GAP_C) ? wcnt : wcnt_inc[WCNT_W-1:0];
   assign too_long   = (wcnt_inc > MAX_X);
   assign last_pulse = (pcnt == PULSES_C);

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      pcnt_nxt  = pcnt;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = HIGH;
               wcnt_nxt  = WCNT_ONE;
               pcnt_nxt  = '0;
            end
         end
         HIGH: begin
            if (fall) begin
               if (wcnt < MIN_C) begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
                  wcnt_nxt  = '0;
               end else begin
                  state_nxt = LOW;
                  wcnt_nxt  = WCNT_ONE;
                  pcnt_nxt  = pcnt + PCNT_ONE;
               end
            end else if (too_long) begin
               state_nxt = ERR;
               err_nxt   = 1'b1;
               wcnt_nxt  = '0;
            end else begin
               wcnt_nxt = wcnt_sat;
            end
         end
         LOW: begin
            if (rise) begin
               if (last_pulse || (wcnt < MIN_C)) begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
                  wcnt_nxt  = '0;
               end else begin
                  state_nxt = HIGH;
                  wcnt_nxt  = WCNT_ONE;
               end
            end else if (!last_pulse && too_long) begin
               state_nxt = ERR;
               err_nxt   = 1'b1;
               wcnt_nxt  = '0;
            end else if (last_pulse && (wcnt == GAP_C)) begin
               state_nxt = IDLE;
               valid_nxt = 1'b1;
               wcnt_nxt  = '0;
            end else begin
               wcnt_nxt = wcnt_sat;
            end
         end
         default: begin
            if (in_sync) begin
               wcnt_nxt = '0;
            end else if (wcnt_inc >= GAP_X) begin
               state_nxt = IDLE;
               wcnt_nxt  = '0;
            end else begin
               wcnt_nxt = wcnt_sat;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         wcnt  <= '0;
         pcnt  <= '0;
         in_d  <= 1'b0;
         valid <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         pcnt  <= pcnt_nxt;
         in_d  <= in_sync;
         valid <= valid_nxt;
         err   <= err_nxt;
         busy  <= (state_nxt != IDLE);
      end
   end

`ifdef PULSE_TRAIN_RX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_count  <= '0;
         err_count <= '0;
      end else begin
         if (valid && (ok_count != 16'hFFFF)) ok_count <= ok_count + 16'd1;
         if (err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pulse_train_rx.sv
// Directed bench for pulse_train_rx at CLKS=2, TOL=1, PULSES=3 (MIN=1, MAX=3, GAP=4).
// Inputs change on negedge; outputs sampled on negedge. Stats checks run when PULSE_TRAIN_RX_STATS_EN is defined.
module tb_pulse_train_rx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic din   = 1'b0;
   logic valid;
   logic err;
   logic busy;
`ifdef PULSE_TRAIN_RX_STATS_EN
   logic [15:0] ok_count;
   logic [15:0] err_count;
`endif

   int          errors = 0;
   int          checks = 0;
   int unsigned edge_n = 0;
   int          valid_seen = 0;
   int          err_seen = 0;
   int          both_total = 0;
   int unsigned valid_edge = 0;
   int unsigned err_edge = 0;

   pulse_train_rx #(
      .CLKS_PER_HALF_PERIOD (2),
      .PULSES               (3),
      .TOLERANCE            (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (din),
      .valid     (valid),
      .err       (err),
      .busy      (busy)
`ifdef PULSE_TRAIN_RX_STATS_EN
      ,
      .ok_count  (ok_count),
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Strobe recorder: edge_n at a negedge is the number of posedges seen so far.
   always @(negedge clk) begin
      if (valid) begin
         valid_seen = valid_seen + 1;
         valid_edge = edge_n;
      end
      if (err) begin
         err_seen = err_seen + 1;
         err_edge = edge_n;
      end
      if (valid && err) both_total = both_total + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic lvl, input int n);
      din = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic burst(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 2);
         drive(1'b0, 2);
      end
   endtask

   task automatic clear_mon();
      valid_seen = 0;
      err_seen   = 0;
      valid_edge = 0;
      err_edge   = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      din   = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_nominal();
      int unsigned l;
      clear_mon();
      din = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_early: got %b expected 0", busy); end
      din = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_rise3: got %b expected 1", busy); end
      @(negedge clk);
      burst(1);
      drive(1'b1, 2);
      l   = edge_n;
      din = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nom_valid_early: got %b expected 0", valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_before_valid: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL nom_valid_at7: got %b expected 1", valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_at_valid: got %b expected 0", busy); end
      repeat (8) @(negedge clk);
      checks++; if (valid_seen !== 1) begin errors++; $display("FAIL nom_valid_count: got %0d expected 1", valid_seen); end
      checks++; if (valid_edge !== l + 7) begin errors++; $display("FAIL nom_valid_latency: got %0d expected %0d", valid_edge - l, 7); end
      checks++; if (err_seen !== 0) begin errors++; $display("FAIL nom_err_count: got %0d expected 0", err_seen); end
   endtask

   task automatic test_long_high();
      int unsigned t;
      clear_mon();
      burst(1);
      t   = edge_n;
      din = 1'b1;
      repeat (4) @(negedge clk);
      din = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL long_err_strobe: got %b expected 1", err); end
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL long_err_one_cycle: got %b expected 0", err); end
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL long_busy_recovery: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_busy_drop: got %b expected 0", busy); end
      repeat (6) @(negedge clk);
      checks++; if (err_seen !== 1) begin errors++; $display("FAIL long_err_count: got %0d expected 1", err_seen); end
      checks++; if (err_edge !== t + 6) begin errors++; $display("FAIL long_err_time: got %0d expected %0d", err_edge - t, 6); end
      checks++; if (valid_seen !== 0) begin errors++; $display("FAIL long_valid_count: got %0d expected 0", valid_seen); end
   endtask

   task automatic test_short_burst();
      int unsigned l;
      clear_mon();
      burst(1);
      drive(1'b1, 2);
      l = edge_n;
      drive(1'b0, 12);
      checks++; if (err_seen !== 1) begin errors++; $display("FAIL short_err_count: got %0d expected 1", err_seen); end
      checks++; if (err_edge !== l + 6) begin errors++; $display("FAIL short_err_time: got %0d expected %0d", err_edge - l, 6); end
      checks++; if (valid_seen !== 0) begin errors++; $display("FAIL short_valid_count: got %0d expected 0", valid_seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_extra_pulse();
      int unsigned r;
      clear_mon();
      burst(3);
      r = edge_n;
      drive(1'b1, 2);
      drive(1'b0, 12);
      checks++; if (err_seen !== 1) begin errors++; $display("FAIL extra_err_count: got %0d expected 1", err_seen); end
      checks++; if (err_edge !== r + 3) begin errors++; $display("FAIL extra_err_time: got %0d expected %0d", err_edge - r, 3); end
      checks++; if (valid_seen !== 0) begin errors++; $display("FAIL extra_valid_count: got %0d expected 0", valid_seen); end
      clear_mon();
      burst(3);
      drive(1'b0, 10);
      checks++; if (valid_seen !== 1) begin errors++; $display("FAIL extra_next_valid: got %0d expected 1", valid_seen); end
      checks++; if (err_seen !== 0) begin errors++; $display("FAIL extra_next_err: got %0d expected 0", err_seen); end
   endtask

   task automatic test_stuck_high();
      int unsigned t;
      clear_mon();
      t = edge_n;
      drive(1'b1, 20);
      din = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stuck_busy_hold: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stuck_busy_drop: got %b expected 0", busy); end
      checks++; if (err_seen !== 1) begin errors++; $display("FAIL stuck_err_count: got %0d expected 1", err_seen); end
      checks++; if (err_edge !== t + 6) begin errors++; $display("FAIL stuck_err_time: got %0d expected %0d", err_edge - t, 6); end
      repeat (4) @(negedge clk);
      clear_mon();
      burst(3);
      drive(1'b0, 10);
      checks++; if (valid_seen !== 1) begin errors++; $display("FAIL stuck_next_valid: got %0d expected 1", valid_seen); end
   endtask

   task automatic test_reset_mid();
      int unsigned l;
      clear_mon();
      burst(1);
      din = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
      din = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async: got %b expected 0", busy); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_async: got %b expected 0", valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err_async: got %b expected 0", err); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      drive(1'b0, 2);
      drive(1'b1, 2);
      l = edge_n;
      drive(1'b0, 12);
      checks++; if (err_seen !== 1) begin errors++; $display("FAIL rstmid_err_count: got %0d expected 1", err_seen); end
      checks++; if (err_edge !== l + 6) begin errors++; $display("FAIL rstmid_err_time: got %0d expected %0d", err_edge - l, 6); end
      checks++; if (valid_seen !== 0) begin errors++; $display("FAIL rstmid_valid_count: got %0d expected 0", valid_seen); end
   endtask

`ifdef PULSE_TRAIN_RX_STATS_EN
   task automatic test_stats();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (ok_count !== 16'd0) begin errors++; $display("FAIL stats_ok_reset: got %0d expected 0", ok_count); end
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL stats_err_reset: got %0d expected 0", err_count); end
      for (int i = 0; i < 2; i++) begin
         burst(3);
         drive(1'b0, 10);
      end
      burst(2);
      drive(1'b0, 12);
      checks++; if (ok_count !== 16'd2) begin errors++; $display("FAIL stats_ok_count: got %0d expected 2", ok_count); end
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL stats_err_count: got %0d expected 1", err_count); end
      force dut.ok_count = 16'hFFFF;
      @(negedge clk);
      release dut.ok_count;
      burst(3);
      drive(1'b0, 10);
      checks++; if (ok_count !== 16'hFFFF) begin errors++; $display("FAIL stats_ok_saturate: got %h expected ffff", ok_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_long_high();
      test_short_burst();
      test_extra_pulse();
      test_stuck_high();
      test_reset_mid();
`ifdef PULSE_TRAIN_RX_STATS_EN
      test_stats();
`endif
      checks++; if (both_total !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d cycles expected 0", both_total); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
